prog_load_sequencer: RTL
========================

PROG_LOAD_SEQUENCER -- requirements
Module: prog_load_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  - ADDR_W, 12, instruction-memory word-address width.
  - MAX_WORDS, 4096, largest accepted payload length.
  - TIMEOUT_CYC, 1_000_000, idle cycles tolerated mid-load.
REQ-002 Ports, one per line (name, direction, width, meaning):
  - clk, in, 1, system clock.
  - Rst, in, 1, reset: asynchronous, active-low.
  - word_valid, in, 1, 32-bit word available from the UART word FIFO.
  - word_data, in, 32, word from the UART word FIFO.
  - word_rdy, out, 1, sequencer accepts word; transfer when word_valid&&word_rdy.
  - imem_we, out, 1, instruction-memory write strobe.
  - imem_addr, out, ADDR_W, instruction-memory word address.
  - imem_wdata, out, 32, instruction-memory write data.
  - state_load_prog, out, 1, CPU held in reset while high.
  - load_done, out, 1, one-cycle pulse on successful load.
  - load_err, out, 1, sticky error flag, cleared by the next accepted magic word.
  - err_code, out, 2, 0 none, 1 bad length, 2 checksum, 3 timeout.

Function
REQ-003 The state machine SHALL have states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-004 IDLE: word_rdy=1; a transfer equal to MAGIC (0x5A5A_0001) → LEN and clears load_err and err_code; any other word is discarded, stay IDLE.
REQ-005 LEN: word_rdy=1; a transfer of N with 1≤N≤MAX_WORDS latches N → DATA; N=0 or N>MAX_WORDS → ERR, err_code=1.
REQ-006 state_load_prog SHALL be high in LEN, DATA, CSUM and DONE, and low in IDLE and ERR.
REQ-007 DATA: word_rdy=1; each transfer drives imem_we=1, imem_wdata=word, imem_addr=index on the next cycle (registered, latency 1).
REQ-008 Index SHALL start at 0, increment per transfer, and never wrap; the N-th transfer → CSUM (or DONE, see REQ-013).
REQ-009 imem_we SHALL be a single-cycle pulse per word; back-to-back transfers produce back-to-back writes.
REQ-010 The running sum SHALL be the mod-2^32 sum of the payload words only.
REQ-011 CSUM: one transfer; if equal to the sum → DONE, otherwise → ERR with err_code=2.
REQ-012 DONE lasts one cycle and SHALL pulse load_done, then → IDLE.
REQ-013 Timeout: in LEN, DATA or CSUM, TIMEOUT_CYC consecutive cycles without a transfer → ERR, err_code=3.
  - The counter resets on every transfer.
REQ-014 ERR lasts one cycle with word_rdy=0, then → IDLE; load_err stays high.
REQ-015 word_valid is don't-care while word_rdy=0; no word is lost or duplicated across state changes.

Reset
REQ-016 Rst low SHALL immediately force the following, including mid-load (no partial write completes after assertion):
  - state IDLE;
  - word_rdy=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - state_load_prog=0, load_done=0, load_err=0, err_code=0;
  - counters 0.
REQ-017 word_rdy SHALL go high on the first clk edge after Rst deasserts.

Configuration
REQ-018 With PROG_CHECKSUM_EN defined: CSUM state, checksum compare and err_code=2 are present.
REQ-019 Without PROG_CHECKSUM_EN:
  - DATA → DONE directly after the N-th word;
  - no checksum word is consumed;
  - err_code=2 never occurs.

Structure
REQ-020 Package prog_load_pkg SHALL hold the state enum typedef, MAGIC, and the err_code localparams.
REQ-021 The timeout counter SHALL be sub-module prog_timeout_ctr (inputs: clear, enable; output: expired).
  - All other logic stays in prog_load_sequencer.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - MAGIC, 3, 0x11, 0x22, 0x33, checksum 0x66 → three writes to addresses 0..2 with those data, load_done pulse, state_load_prog falls.
  - MAGIC, 3, 0x11, 0x22, 0x33, checksum 0x67 → writes occur, ERR, err_code=2, load_err=1, no load_done.
  - MAGIC then 0 → ERR, err_code=1.
  - MAGIC then MAX_WORDS+1 → ERR, err_code=1.
  - MAGIC, 2, 0xAA, then silence for TIMEOUT_CYC cycles → err_code=3, state_load_prog=0.
  - Rst pulse after the 2nd of 4 data words → all outputs reset immediately; a fresh MAGIC load then succeeds from address 0.
  - Garbage words 0x1234, 0xFFFF_FFFF in IDLE → discarded, state_load_prog stays 0.
  - With PROG_CHECKSUM_EN undefined: MAGIC, 2, 0x5, 0x6 → load_done after the 2nd write, no checksum word consumed.

Source files
------------

// File: rtl/prog_load_sequencer_pkg.sv
// Shared definitions for the program-load sequencer: FSM state encoding,
// the load-start magic word and the err_code values.
package prog_load_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Word that opens a load sequence.
    localparam logic [31:0] MAGIC = 32'h5A5A_0001;

    // err_code values reported alongside load_err.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/prog_load_sequencer_if.sv
// Bus between the UART word FIFO / instruction memory / CPU control and the
// program-load sequencer. master = word source and observers, slave = sequencer.
interface prog_load_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              word_valid;
    logic [31:0]       word_data;
    logic              word_rdy;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              state_load_prog;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;

    modport master (
        output word_valid, word_data,
        input  word_rdy, imem_we, imem_addr, imem_wdata,
        input  state_load_prog, load_done, load_err, err_code
    );

    modport slave (
        input  word_valid, word_data,
        output word_rdy, imem_we, imem_addr, imem_wdata,
        output state_load_prog, load_done, load_err, err_code
    );
endinterface

// File: rtl/prog_load_sequencer_timeout.sv
// Idle-cycle watchdog for the program-load sequencer. Counts consecutive
// enabled cycles without a clear; expired is asserted during the
// TIMEOUT_CYC-th such cycle so the FSM can leave on the following edge.
module prog_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Count idle cycles; any clear or leaving the waiting states restarts it.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            cnt_reg <= '0;
        end else if (clear || !enable) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (cnt_reg == LAST);
endmodule

// File: rtl/prog_load_sequencer.sv
// Program-load sequencer: accepts MAGIC, a length N and N payload words from
// the UART word FIFO, writes them to instruction memory from address 0 and
// holds the CPU in reset while loading.
// Optional feature macro PROG_CHECKSUM_EN: when defined, a trailing mod-2^32
// checksum word is consumed and compared; when undefined, the load finishes
// directly after the N-th payload word.
module prog_load_sequencer
    import prog_load_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MAX_WORDS   = 4096,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 Rst,
    prog_load_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t            state_reg, state_next;
    logic              rdy_en_reg;
    logic [IDX_W-1:0]  len_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic              load_err_reg;
    logic [1:0]        err_code_reg;

    logic              word_rdy;
    logic              xfer;
    logic              wait_state;
    logic              len_valid;
    logic              last_word;
    logic              magic_hit;
    logic              err_set;
    logic [1:0]        err_code_next;
    logic              tmo_clear;
    logic              tmo_expired;

`ifdef PROG_CHECKSUM_EN
    logic [31:0]       sum_reg;
`endif

    // States in which the sequencer is waiting on the word stream.
    assign wait_state = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM);
    // rdy_en_reg keeps word_rdy low until the first edge after reset release.
    assign word_rdy   = rdy_en_reg && ((state_reg == IDLE) || wait_state);
    assign xfer       = bus.word_valid && word_rdy;
    assign len_valid  = (bus.word_data != 32'd0) && (bus.word_data <= 32'(MAX_WORDS));
    assign last_word  = (idx_reg + IDX_W'(1)) == len_reg;
    assign tmo_clear  = xfer || !wait_state;

    prog_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .Rst     (Rst),
        .clear   (tmo_clear),
        .enable  (wait_state),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_reg  <= IDLE;
            rdy_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rdy_en_reg <= 1'b1;
        end
    end

    // Next-state logic plus error / magic decode.
    always_comb begin
        state_next    = state_reg;
        magic_hit     = 1'b0;
        err_set       = 1'b0;
        err_code_next = ERR_NONE;
        case (state_reg)
            IDLE: begin
                if (xfer && (bus.word_data == MAGIC)) begin
                    state_next = LEN;
                    magic_hit  = 1'b1;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (len_valid) begin
                        state_next = DATA;
                    end else begin
                        state_next    = ERR;
                        err_set       = 1'b1;
                        err_code_next = ERR_LEN;
                    end
                end else if (tmo_expired) begin
                    state_next    = ERR;
                    err_set       = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (last_word) begin
`ifdef PROG_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end
                end else if (tmo_expired) begin
                    state_next    = ERR;
                    err_set       = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            CSUM: begin
`ifdef PROG_CHECKSUM_EN
                if (xfer) begin
                    if (bus.word_data == sum_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next    = ERR;
                        err_set       = 1'b1;
                        err_code_next = ERR_CSUM;
                    end
                end else if (tmo_expired) begin
                    state_next    = ERR;
                    err_set       = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the payload length and restart the write index on a valid length.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            len_reg <= '0;
            idx_reg <= '0;
        end else if ((state_reg == LEN) && xfer && len_valid) begin
            len_reg <= IDX_W'(bus.word_data);
            idx_reg <= '0;
        end else if ((state_reg == DATA) && xfer) begin
            idx_reg <= idx_reg + IDX_W'(1);
        end
    end

    // Registered instruction-memory write port: one strobe per payload word.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
        end else begin
            imem_we_reg <= 1'b0;
            if ((state_reg == DATA) && xfer) begin
                imem_we_reg    <= 1'b1;
                imem_addr_reg  <= ADDR_W'(idx_reg);
                imem_wdata_reg <= bus.word_data;
            end
        end
    end

`ifdef PROG_CHECKSUM_EN
    // Running mod-2^32 sum of payload words, restarted at each length word.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sum_reg <= '0;
        end else if ((state_reg == LEN) && xfer) begin
            sum_reg <= '0;
        end else if ((state_reg == DATA) && xfer) begin
            sum_reg <= sum_reg + bus.word_data;
        end
    end
`endif

    // Sticky error flag and code; a new MAGIC clears them.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            load_err_reg <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else if (err_set) begin
            load_err_reg <= 1'b1;
            err_code_reg <= err_code_next;
        end else if (magic_hit) begin
            load_err_reg <= 1'b0;
            err_code_reg <= ERR_NONE;
        end
    end

    assign bus.word_rdy        = word_rdy;
    assign bus.imem_we         = imem_we_reg;
    assign bus.imem_addr       = imem_addr_reg;
    assign bus.imem_wdata      = imem_wdata_reg;
    assign bus.state_load_prog = wait_state || (state_reg == DONE);
    assign bus.load_done       = (state_reg == DONE);
    assign bus.load_err        = load_err_reg;
    assign bus.err_code        = err_code_reg;
endmodule
